// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared mode/op constants and sequencer state for alu_seq
package alu_pkg;

    localparam logic [1:0] MODE_ARITH = 2'd0;
    localparam logic [1:0] MODE_MULU  = 2'd1;
    localparam logic [1:0] MODE_DIVU  = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_OR  = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arith_unit.sv
// rtl/alu_arith_unit.sv - single-cycle add/logic path on sign-extended operands
module alu_arith_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             less_than,
    output logic             overflow
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] ext;

    always_comb begin
        a_ext = {a[WIDTH-1], a};
        b_ext = {b[WIDTH-1], b};
        if (op[3]) a_ext = ~a_ext;
        if (op[2]) b_ext = ~b_ext;
        case (op[1:0])
            OP_ADD:  ext = a_ext + b_ext + {{WIDTH{1'b0}}, op[2]};
            OP_AND:  ext = a_ext & b_ext;
            OP_OR:   ext = a_ext | b_ext;
            default: ext = a_ext ^ b_ext;
        endcase
    end

    // The extra top bit makes signed overflow visible as a sign disagreement.
    assign result    = ext[WIDTH-1:0];
    assign less_than = ext[WIDTH-1];
    assign overflow  = ext[WIDTH] ^ ext[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with start/done handshake, shift-add MUL and restoring DIV
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [3:0]       aluOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             equal,
    output logic             lessThan,
    output logic             overflow,
    output logic             divByZero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             iterative;
    logic [CW-1:0]    cnt;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] b_q;
    logic             eq_q;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     mul_sum;

    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH+1:0] div_shift;
    logic [WIDTH+1:0] div_trial;

    logic [WIDTH-1:0] arith_result;
    logic             arith_lt;
    logic             arith_ov;

    alu_arith_unit #(.WIDTH(WIDTH)) u_arith (
        .a         (A),
        .b         (B),
        .op        (aluOp),
        .result    (arith_result),
        .less_than (arith_lt),
        .overflow  (arith_ov)
    );

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign accept    = start && (state != ST_RUN);
    assign iterative = (mode == MODE_MULU) || (mode == MODE_DIVU);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start)                state_next = iterative ? ST_RUN : ST_DONE;
                else if (state == ST_DONE) state_next = ST_IDLE;
            end
            ST_RUN:  if (cnt == '0) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // One shift-add step: add multiplicand when the low multiplier bit is set, then shift right.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_q} : '0);
        prod_next = {mul_sum, prod[WIDTH-1:1]};
    end

    // One restoring step: shift in the next dividend bit and keep the difference if non-negative.
    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_trial = div_shift - {2'b00, b_q};
        if (div_trial[WIDTH+1]) begin
            rem_next = div_shift[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = div_trial[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            mode_q    <= MODE_ARITH;
            b_q       <= '0;
            eq_q      <= 1'b0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            out       <= '0;
            hi        <= '0;
            equal     <= 1'b0;
            lessThan  <= 1'b0;
            overflow  <= 1'b0;
            divByZero <= 1'b0;
        end else if (accept) begin
            mode_q <= mode;
            b_q    <= B;
            eq_q   <= (A == B);
            cnt    <= CW'(WIDTH - 1);
            prod   <= {{WIDTH{1'b0}}, A};
            rem    <= '0;
            quo    <= A;
            if (mode == MODE_ARITH) begin
                out       <= arith_result;
                hi        <= '0;
                equal     <= (A == B);
                lessThan  <= arith_lt;
                overflow  <= arith_ov;
                divByZero <= 1'b0;
            end else if (mode == MODE_RSVD) begin
                out       <= '0;
                hi        <= '0;
                equal     <= 1'b0;
                lessThan  <= 1'b0;
                overflow  <= 1'b0;
                divByZero <= 1'b0;
            end
        end else if (state == ST_RUN) begin
            prod <= prod_next;
            rem  <= rem_next;
            quo  <= quo_next;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (mode_q == MODE_MULU) begin
                out       <= prod_next[WIDTH-1:0];
                hi        <= prod_next[2*WIDTH-1:WIDTH];
                equal     <= eq_q;
                lessThan  <= 1'b0;
                overflow  <= |prod_next[2*WIDTH-1:WIDTH];
                divByZero <= 1'b0;
            end else begin
                out       <= quo_next;
                hi        <= rem_next[WIDTH-1:0];
                equal     <= eq_q;
                lessThan  <= 1'b0;
                overflow  <= 1'b0;
                divByZero <= (b_q == '0);
            end
        end
    end

endmodule
